// File: rtl/aes_key_schedule_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES key
// schedule. The S-box is computed algebraically (multiplicative inverse
// followed by the AES affine map) rather than stored as a table.
package aes_key_schedule_pkg;

   typedef logic [7:0]   byte_t;
   typedef logic [31:0]  word_t;
   typedef logic [127:0] block_t;

   typedef enum logic [1:0] {
      AES128 = 2'd0,
      AES192 = 2'd1,
      AES256 = 2'd2
   } key_len_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GEN  = 2'd1,
      OUT  = 2'd2
   } state_e;

   localparam int NK_AES128 = 4;
   localparam int NK_AES192 = 6;
   localparam int NK_AES256 = 8;
   localparam int NR_AES128 = 10;
   localparam int NR_AES192 = 12;
   localparam int NR_AES256 = 14;

   function automatic key_len_e key_len_of(input int key_bits);
      case (key_bits)
         192:     return AES192;
         256:     return AES256;
         default: return AES128;
      endcase
   endfunction

   function automatic int nk_of(input key_len_e len);
      case (len)
         AES192:  return NK_AES192;
         AES256:  return NK_AES256;
         default: return NK_AES128;
      endcase
   endfunction

   function automatic int nr_of(input key_len_e len);
      case (len)
         AES192:  return NR_AES192;
         AES256:  return NR_AES256;
         default: return NR_AES128;
      endcase
   endfunction

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic byte_t xtime(input byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic byte_t gf_mul(input byte_t a, input byte_t b);
      byte_t p;
      byte_t aa;
      p  = '0;
      aa = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box requires.
   function automatic byte_t gf_inv(input byte_t a);
      byte_t sq;
      byte_t acc;
      sq  = a;
      acc = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic byte_t aes_sbox(input byte_t a);
      byte_t v;
      v = gf_inv(a);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
               ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   function automatic word_t sub_word(input word_t w);
      return {aes_sbox(w[31:24]), aes_sbox(w[23:16]),
              aes_sbox(w[15:8]),  aes_sbox(w[7:0])};
   endfunction

   function automatic word_t rot_word(input word_t w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Key-load and round-key stream bundle for aes_key_schedule.
//   i_key_valid/o_key_ready/i_key : cipher key handshake (word 0 in MSBs)
//   o_rk_valid/i_rk_ready         : round key stream with backpressure
//   o_round_key/o_round_idx/o_last: round key payload
//   i_flush                       : synchronous abort
//   o_busy                        : engine not idle
// master = key source / round-key consumer, slave = key schedule.
interface aes_key_schedule_if
   import aes_key_schedule_pkg::*;
#(
   parameter int KEY_BITS = 128
);
   logic                i_key_valid;
   logic                o_key_ready;
   logic [KEY_BITS-1:0] i_key;
   logic                o_rk_valid;
   logic                i_rk_ready;
   block_t              o_round_key;
   logic [3:0]          o_round_idx;
   logic                o_last;
   logic                i_flush;
   logic                o_busy;

   modport master (
      output i_key_valid, i_key, i_rk_ready, i_flush,
      input  o_key_ready, o_rk_valid, o_round_key, o_round_idx, o_last, o_busy
   );

   modport slave (
      input  i_key_valid, i_key, i_rk_ready, i_flush,
      output o_key_ready, o_rk_valid, o_round_key, o_round_idx, o_last, o_busy
   );
endinterface

// File: rtl/aes_key_schedule_key_word_gen.sv
// Combinational next-word generator for the sliding-window key expansion.
//   old_i      : oldest window word W[i-NK]
//   new_i      : newest window word W[i-1]
//   rcon_i     : current round constant
//   idx_i      : word counter i
//   word_o     : W[i]
//   rcon_adv_o : W[i] consumed rcon, advance it
module aes_key_schedule_key_word_gen
   import aes_key_schedule_pkg::*;
#(
   parameter int NK = 4
) (
   input  word_t       old_i,
   input  word_t       new_i,
   input  byte_t       rcon_i,
   input  logic [5:0]  idx_i,
   output word_t       word_o,
   output logic        rcon_adv_o
);
   localparam logic [5:0] NK_W   = 6'(NK);
   localparam bit         IS_256 = (NK == 8);

   logic [5:0] i_mod;
   assign i_mod = idx_i % NK_W;

   // While i < NK the window simply recirculates the cipher key words.
   always_comb begin
      word_o     = old_i;
      rcon_adv_o = 1'b0;
      if (idx_i >= NK_W) begin
         if (i_mod == 6'd0) begin
            word_o     = old_i ^ sub_word(rot_word(new_i)) ^ {rcon_i, 24'h0};
            rcon_adv_o = 1'b1;
         end else if (IS_256 && (i_mod == 6'd4)) begin
            word_o = old_i ^ sub_word(new_i);
         end else begin
            word_o = old_i ^ new_i;
         end
      end
   end
endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128/192/256 key schedule. Accepts one cipher key, produces
// one expanded word per cycle through an NK-word window and emits NR+1
// round keys as 128-bit blocks over a backpressured stream.
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : aes_key_schedule_if.slave (key load, round-key stream, flush)
//
// state | meaning
// IDLE  | waiting for a cipher key, o_key_ready high
// GEN   | generating one word per cycle into window and assembly register
// OUT   | round key presented, held until consumer accepts it
module aes_key_schedule
   import aes_key_schedule_pkg::*;
#(
   parameter int KEY_BITS = 128
) (
   input  logic                 clock,
   input  logic                 reset,
   aes_key_schedule_if.slave    bus
);
   localparam key_len_e   KEY_LEN  = key_len_of(KEY_BITS);
   localparam int         NK       = nk_of(KEY_LEN);
   localparam int         NR       = nr_of(KEY_LEN);
   localparam logic [3:0] LAST_IDX = 4'(NR);

   if ((KEY_BITS != 128) && (KEY_BITS != 192) && (KEY_BITS != 256)) begin : g_bad_key_bits
      $error("aes_key_schedule: KEY_BITS must be 128, 192 or 256");
   end

   state_e          state_q;
   word_t [NK-1:0]  win_q;      // [0] oldest, [NK-1] newest
   word_t [NK-1:0]  win_d;
   block_t          asm_q;
   block_t          asm_d;
   logic [5:0]      cnt_q;
   byte_t           rcon_q;
   logic [3:0]      rnd_q;
   logic            rk_valid_q;
   block_t          round_key_q;
   logic [3:0]      round_idx_q;
   logic            last_q;

   word_t           word_nxt;
   logic            rcon_adv;

   aes_key_schedule_key_word_gen #(
      .NK (NK)
   ) u_key_word_gen (
      .old_i      (win_q[0]),
      .new_i      (win_q[NK-1]),
      .rcon_i     (rcon_q),
      .idx_i      (cnt_q),
      .word_o     (word_nxt),
      .rcon_adv_o (rcon_adv)
   );

   assign win_d = {word_nxt, win_q[NK-1:1]};
   assign asm_d = {asm_q[95:0], word_nxt};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         win_q       <= '0;
         asm_q       <= '0;
         cnt_q       <= '0;
         rcon_q      <= 8'h01;
         rnd_q       <= '0;
         rk_valid_q  <= 1'b0;
         round_key_q <= '0;
         round_idx_q <= '0;
         last_q      <= 1'b0;
      end else if (bus.i_flush) begin
         state_q    <= IDLE;
         rk_valid_q <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.i_key_valid) begin
                  for (int k = 0; k < NK; k++) begin
                     win_q[k] <= bus.i_key[KEY_BITS-1-32*k -: 32];
                  end
                  cnt_q   <= '0;
                  rcon_q  <= 8'h01;
                  rnd_q   <= '0;
                  state_q <= GEN;
               end
            end
            GEN: begin
               win_q <= win_d;
               asm_q <= asm_d;
               cnt_q <= cnt_q + 6'd1;
               if (rcon_adv) rcon_q <= xtime(rcon_q);
               // Fourth word of a block completes a round key.
               if (cnt_q[1:0] == 2'b11) begin
                  round_key_q <= asm_d;
                  rk_valid_q  <= 1'b1;
                  round_idx_q <= rnd_q;
                  last_q      <= (rnd_q == LAST_IDX);
                  state_q     <= OUT;
               end
            end
            OUT: begin
               if (bus.i_rk_ready) begin
                  rk_valid_q <= 1'b0;
                  if (last_q) begin
                     last_q  <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     rnd_q   <= rnd_q + 4'd1;
                     state_q <= GEN;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.o_key_ready = (state_q == IDLE);
   assign bus.o_busy      = (state_q != IDLE);
   assign bus.o_rk_valid  = rk_valid_q;
   assign bus.o_round_key = round_key_q;
   assign bus.o_round_idx = round_idx_q;
   assign bus.o_last      = last_q;
endmodule

// File: tb/tb_aes_key_schedule.sv
module tb_aes_key_schedule;

   typedef struct {
      logic [127:0] rk;
      logic [3:0]   idx;
      logic         last;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   int           sel = 0;
   logic         tb_key_valid = 1'b0;
   logic         tb_rdy = 1'b0;
   logic         tb_flush = 1'b0;
   logic [255:0] tb_key = '0;

   exp_t         exp_q[$];
   logic [127:0] obs_rk [15];
   logic         obs_last [15];
   logic         pend_rst;

   logic [2047:0] sbox_bits = 2048'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0_b7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275_09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf_d0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2_cd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb_e0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08_ba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e_e1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16;
   logic [79:0]   rcon_bits = 80'h01020408102040801b36;

   logic [255:0] k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   logic [255:0] k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   logic [255:0] k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   aes_key_schedule_if #(.KEY_BITS(128)) if128 ();
   aes_key_schedule_if #(.KEY_BITS(192)) if192 ();
   aes_key_schedule_if #(.KEY_BITS(256)) if256 ();

   assign if128.i_key_valid = tb_key_valid && (sel == 0);
   assign if128.i_rk_ready  = tb_rdy && (sel == 0);
   assign if128.i_flush     = tb_flush && (sel == 0);
   assign if128.i_key       = tb_key[255:128];
   assign if192.i_key_valid = tb_key_valid && (sel == 1);
   assign if192.i_rk_ready  = tb_rdy && (sel == 1);
   assign if192.i_flush     = tb_flush && (sel == 1);
   assign if192.i_key       = tb_key[255:64];
   assign if256.i_key_valid = tb_key_valid && (sel == 2);
   assign if256.i_rk_ready  = tb_rdy && (sel == 2);
   assign if256.i_flush     = tb_flush && (sel == 2);
   assign if256.i_key       = tb_key;

   aes_key_schedule #(.KEY_BITS(128)) dut128 (.clock(clk), .reset(rst_n), .bus(if128));
   aes_key_schedule #(.KEY_BITS(192)) dut192 (.clock(clk), .reset(rst_n), .bus(if192));
   aes_key_schedule #(.KEY_BITS(256)) dut256 (.clock(clk), .reset(rst_n), .bus(if256));

   logic         mon_valid, mon_last, mon_kready, mon_busy;
   logic [127:0] mon_rk;
   logic [3:0]   mon_idx;

   always_comb begin
      case (sel)
         1: begin
            mon_valid = if192.o_rk_valid;  mon_last = if192.o_last;
            mon_kready = if192.o_key_ready; mon_busy = if192.o_busy;
            mon_rk = if192.o_round_key;    mon_idx = if192.o_round_idx;
         end
         2: begin
            mon_valid = if256.o_rk_valid;  mon_last = if256.o_last;
            mon_kready = if256.o_key_ready; mon_busy = if256.o_busy;
            mon_rk = if256.o_round_key;    mon_idx = if256.o_round_idx;
         end
         default: begin
            mon_valid = if128.o_rk_valid;  mon_last = if128.o_last;
            mon_kready = if128.o_key_ready; mon_busy = if128.o_busy;
            mon_rk = if128.o_round_key;    mon_idx = if128.o_round_idx;
         end
      endcase
   end

   function automatic logic [7:0] m_sbox(input logic [7:0] b);
      return sbox_bits[2047 - 8*int'(b) -: 8];
   endfunction

   function automatic logic [31:0] m_subw(input logic [31:0] w);
      return {m_sbox(w[31:24]), m_sbox(w[23:16]), m_sbox(w[15:8]), m_sbox(w[7:0])};
   endfunction

   // FIPS-197 style whole-array expansion; key is left-aligned in 256 bits.
   task automatic push_expected(input logic [255:0] key, input int nk);
      logic [31:0] w [60];
      logic [31:0] t;
      int nr;
      exp_t e;
      nr = nk + 6;
      for (int k = 0; k < nk; k++) w[k] = key[255-32*k -: 32];
      for (int k = nk; k < 4*(nr+1); k++) begin
         t = w[k-1];
         if (k % nk == 0)
            t = m_subw({t[23:0], t[31:24]}) ^ {rcon_bits[79 - 8*(k/nk - 1) -: 8], 24'h0};
         else if (nk == 8 && k % nk == 4)
            t = m_subw(t);
         w[k] = w[k-nk] ^ t;
      end
      for (int r = 0; r <= nr; r++) begin
         e.rk   = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         e.idx  = 4'(r);
         e.last = (r == nr);
         exp_q.push_back(e);
      end
   endtask

   function automatic logic [255:0] rand_key();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic load_key(input logic [255:0] key, input int nk);
      @(negedge clk);
      checks++;
      if (mon_kready !== 1'b1) begin
         failures++;
         $display("FAIL load_ready: got key_ready=%b want 1", mon_kready);
      end
      tb_key = key;
      tb_key_valid = 1'b1;
      push_expected(key, nk);
      @(posedge clk);
      #1;
      tb_key_valid = 1'b0;
      tb_key = rand_key();
   endtask

   task automatic collect(input int stall_pct, input int flush_idx, input int reset_idx,
                          input bit chk_timing, input bit poke_key, output int n_hs);
      int c;
      bit done;
      bit rdy;
      bit got_last;
      exp_t e;
      c = 0; done = 0; n_hs = 0; got_last = 0; pend_rst = 0;
      for (int r = 0; r < 15; r++) begin obs_rk[r] = '0; obs_last[r] = 1'b0; end
      while (!done) begin
         @(negedge clk);
         rdy = ($urandom_range(99) >= stall_pct);
         if (c >= 3000) begin
            checks++; failures++;
            $display("FAIL collect_timeout: got %0d keys after %0d cycles, want last key", n_hs, c);
            done = 1;
            continue;
         end
         if (pend_rst) begin
            rst_n = 1'b0;
            #1;
            checks++;
            if (mon_valid !== 1'b0 || mon_rk !== '0 || mon_idx !== 4'd0 || mon_last !== 1'b0 ||
                mon_kready !== 1'b1 || mon_busy !== 1'b0) begin
               failures++;
               $display("FAIL mid_reset: got valid=%b rk=%h idx=%0d last=%b ready=%b busy=%b want 0/0/0/0/1/0",
                        mon_valid, mon_rk, mon_idx, mon_last, mon_kready, mon_busy);
            end
            @(negedge clk);
            rst_n = 1'b1;
            exp_q.delete();
            repeat (8) @(negedge clk);
            checks++;
            if (mon_valid !== 1'b0 || mon_busy !== 1'b0) begin
               failures++;
               $display("FAIL after_reset_quiet: got valid=%b busy=%b want 0/0", mon_valid, mon_busy);
            end
            done = 1;
            continue;
         end
         if (mon_valid) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_key: got idx=%0d want no key", mon_idx);
               done = 1;
               continue;
            end
            if (flush_idx >= 0 && int'(mon_idx) == flush_idx) begin
               tb_rdy = 1'b0;
               tb_flush = 1'b1;
               @(negedge clk);
               tb_flush = 1'b0;
               checks++;
               if (mon_valid !== 1'b0 || mon_kready !== 1'b1 || mon_last !== 1'b0 || mon_busy !== 1'b0) begin
                  failures++;
                  $display("FAIL flush_abort: got valid=%b ready=%b last=%b busy=%b want 0/1/0/0",
                           mon_valid, mon_kready, mon_last, mon_busy);
               end
               exp_q.delete();
               tb_flush = 1'b1;
               tb_key_valid = 1'b1;
               tb_key = rand_key();
               @(negedge clk);
               tb_flush = 1'b0;
               tb_key_valid = 1'b0;
               checks++;
               if (mon_busy !== 1'b0) begin
                  failures++;
                  $display("FAIL flush_blocks_load: got busy=%b want 0", mon_busy);
               end
               done = 1;
               continue;
            end
            if (!rdy) begin
               checks++;
               if (mon_rk !== exp_q[0].rk || mon_idx !== exp_q[0].idx || mon_kready !== 1'b0) begin
                  failures++;
                  $display("FAIL stall_hold: got rk=%h idx=%0d ready=%b want rk=%h idx=%0d ready=0",
                           mon_rk, mon_idx, mon_kready, exp_q[0].rk, exp_q[0].idx);
               end
            end else begin
               e = exp_q.pop_front();
               n_hs++;
               checks++;
               if (mon_rk !== e.rk || mon_idx !== e.idx || mon_last !== e.last) begin
                  failures++;
                  $display("FAIL round_key: got rk=%h idx=%0d last=%b want rk=%h idx=%0d last=%b",
                           mon_rk, mon_idx, mon_last, e.rk, e.idx, e.last);
               end
               obs_rk[e.idx] = mon_rk;
               obs_last[e.idx] = mon_last;
               if (chk_timing) begin
                  checks++;
                  if (c != 5*int'(e.idx) + 4) begin
                     failures++;
                     $display("FAIL key_latency: got cycle %0d want %0d for idx %0d", c, 5*int'(e.idx) + 4, e.idx);
                  end
               end
               if (e.last) begin got_last = 1; done = 1; end
               if (reset_idx >= 0 && int'(e.idx) == reset_idx) pend_rst = 1;
            end
         end
         tb_rdy = rdy;
         tb_key_valid = poke_key && !done;
         if (poke_key) tb_key = rand_key();
         c++;
      end
      if (got_last) begin
         @(negedge clk);
         tb_rdy = 1'b0;
         checks++;
         if (mon_busy !== 1'b0 || mon_kready !== 1'b1 || mon_valid !== 1'b0) begin
            failures++;
            $display("FAIL return_idle: got busy=%b ready=%b valid=%b want 0/1/0", mon_busy, mon_kready, mon_valid);
         end
         checks++;
         if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_keys: got %0d pending want 0", exp_q.size());
         end
      end
      tb_rdy = 1'b0;
      tb_key_valid = 1'b0;
   endtask

   task automatic chk_rk(input string name, input int idx, input logic [127:0] want);
      checks++;
      if (obs_rk[idx] !== want) begin
         failures++;
         $display("FAIL %s: got %h want %h", name, obs_rk[idx], want);
      end
   endtask

   task automatic chk_count(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         checks++;
         if (mon_valid !== 1'b0 || mon_rk !== '0 || mon_idx !== 4'd0 || mon_last !== 1'b0 ||
             mon_kready !== 1'b1 || mon_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state[%0d]: got valid=%b rk=%h idx=%0d last=%b ready=%b busy=%b want 0/0/0/0/1/0",
                     s, mon_valid, mon_rk, mon_idx, mon_last, mon_kready, mon_busy);
         end
      end
      sel = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_aes128();
      int n;
      sel = 0;
      load_key(k128, 4);
      collect(0, -1, -1, 1'b1, 1'b0, n);
      chk_count("aes128_count", n, 11);
      chk_rk("aes128_idx0", 0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
      chk_rk("aes128_idx1", 1, 128'ha0fafe1788542cb123a339392a6c7605);
      chk_rk("aes128_idx10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      chk_count("aes128_last", int'(obs_last[10]), 1);
   endtask

   task automatic test_aes192();
      int n;
      sel = 1;
      load_key(k192, 6);
      collect(0, -1, -1, 1'b1, 1'b0, n);
      chk_count("aes192_count", n, 13);
      chk_rk("aes192_idx1", 1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
      chk_rk("aes192_idx12", 12, 128'he98ba06f448c773c8ecc720401002202);
      chk_count("aes192_last", int'(obs_last[12]), 1);
   endtask

   task automatic test_aes256();
      int n;
      sel = 2;
      load_key(k256, 8);
      collect(0, -1, -1, 1'b1, 1'b0, n);
      chk_count("aes256_count", n, 15);
      chk_rk("aes256_idx1", 1, 128'h1f352c073b6108d72d9810a30914dff4);
      chk_rk("aes256_idx14", 14, 128'hfe4890d1e6188d0b046df344706c631e);
      chk_count("aes256_last", int'(obs_last[14]), 1);
   endtask

   task automatic test_backpressure();
      int n;
      sel = 0;
      load_key(k128, 4);
      collect(60, -1, -1, 1'b0, 1'b1, n);
      chk_count("bp_count", n, 11);
      chk_rk("bp_idx10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
   endtask

   task automatic test_flush();
      int n;
      logic [255:0] key;
      sel = 0;
      load_key(k128, 4);
      collect(0, 3, -1, 1'b0, 1'b0, n);
      chk_count("flush_keys_before", n, 3);
      key = rand_key();
      load_key(key, 4);
      collect(0, -1, -1, 1'b1, 1'b0, n);
      chk_count("flush_reload_count", n, 11);
      chk_rk("flush_reload_idx0", 0, key[255:128]);
   endtask

   task automatic test_reset_mid_gen();
      int n;
      sel = 0;
      load_key(k128, 4);
      collect(0, -1, 4, 1'b0, 1'b0, n);
      chk_count("midrst_keys_before", n, 5);
      load_key(k128, 4);
      collect(0, -1, -1, 1'b1, 1'b0, n);
      chk_count("midrst_reload_count", n, 11);
      chk_rk("midrst_reload_idx1", 1, 128'ha0fafe1788542cb123a339392a6c7605);
   endtask

   task automatic test_back_to_back();
      int n;
      for (int s = 0; s < 3; s++) begin
         sel = s;
         for (int rep = 0; rep < 2; rep++) begin
            load_key(rand_key(), 4 + 2*s);
            collect(rep * 30, -1, -1, 1'b0, 1'b0, n);
            chk_count("b2b_count", n, 4 + 2*s + 7);
         end
      end
   endtask

   initial begin
      test_reset();
      test_aes128();
      test_aes192();
      test_aes256();
      test_backpressure();
      test_flush();
      test_reset_mid_gen();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
